// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
//   run_state_t : controller state encoding (also shown on the status display)
//   OP_*        : opcodes used to classify instructions for the counters
//   HEX_*       : display source select codes
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } run_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [2:0] HEX_PC     = 3'd0;
  localparam logic [2:0] HEX_INSTR  = 3'd1;
  localparam logic [2:0] HEX_ALU    = 3'd2;
  localparam logic [2:0] HEX_CNT_IR = 3'd3;
  localparam logic [2:0] HEX_CNT_JC = 3'd4;
  localparam logic [2:0] HEX_STATUS = 3'd5;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Control/observation bundle between the board or bench and the run controller.
//   master : board side (drives run/step/breakpoint/CPU taps, reads status)
//   slave  : controller side
interface cpu_run_controller_if #(
  parameter int CNT_W = 11
);
  logic             run;
  logic             step;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic [31:0]      alu_result;
  logic             expsrc0;
  logic             expsrc1;
  logic             expsrc2;
  logic             cpu_en;
  logic             halted;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_j;
  logic [CNT_W-1:0] cnt_clk;
  logic [31:0]      hex;

  modport master (
    output run, step, bp_en, bp_addr, pc, instr, alu_result,
           expsrc0, expsrc1, expsrc2,
    input  cpu_en, halted, cnt_i, cnt_r, cnt_j, cnt_clk, hex
  );

  modport slave (
    input  run, step, bp_en, bp_addr, pc, instr, alu_result,
           expsrc0, expsrc1, expsrc2,
    output cpu_en, halted, cnt_i, cnt_r, cnt_j, cnt_clk, hex
  );

endinterface

// File: rtl/instr_class_counter.sv
// Saturating up-counter with enable; holds at all-ones.
//   i_clk  : clock
//   i_rst  : synchronous active-high clear
//   i_en   : count enable
//   o_cnt  : current count
module instr_class_counter #(
  parameter int CNT_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_controller.sv
// Execution controller for single_cycle_cpu: gates the CPU commit enable in
// free-run / single-step / halt, counts executed instructions by class and
// drives the hex display mux.
//   external_clk : sole clock, rising edge
//   reset        : synchronous active-high, clears all state
//   bus          : cpu_run_controller_if.slave (controls, CPU taps, status)
//
// state | meaning
// IDLE  | CPU frozen, waiting for run or a step edge
// RUN   | free-running until run drops, breakpoint or cycle budget
// STEP  | exactly one enabled cycle, then back to IDLE
// HALT  | frozen; leaves on run=0 && step=0 unless the budget was hit
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W      = 11,
  parameter int MAX_CYCLES = 1700
) (
  input  logic                 external_clk,
  input  logic                 reset,
  cpu_run_controller_if.slave  bus
);

  run_state_t  r_state;
  logic        r_halted;
  logic        r_step_q;
  logic        r_bp_skip;
  logic        r_limit_hit;
  logic [31:0] r_hex;

  logic             w_step_edge;
  logic             w_bp_hit;
  logic             w_cpu_en;
  logic             w_limit_now;
  logic [5:0]       w_opcode;
  logic [2:0]       w_sel;
  logic [31:0]      w_hex_next;
  logic [CNT_W-1:0] w_cnt_i;
  logic [CNT_W-1:0] w_cnt_r;
  logic [CNT_W-1:0] w_cnt_j;
  logic [CNT_W-1:0] w_cnt_clk;

  assign w_opcode    = bus.instr[31:26];
  assign w_sel       = {bus.expsrc2, bus.expsrc1, bus.expsrc0};
  assign w_step_edge = bus.step && !r_step_q;
  // bp_skip lets a resumed run execute the instruction it stopped on.
  assign w_bp_hit    = bus.bp_en && (bus.pc == bus.bp_addr) && !r_bp_skip;

  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      RUN:     w_cpu_en = !w_bp_hit && !r_limit_hit;
      STEP:    w_cpu_en = !r_limit_hit;
      default: w_cpu_en = 1'b0;
    endcase
  end

  // The enabled cycle that brings cnt_clk up to the budget is the last one.
  assign w_limit_now = w_cpu_en && ((int'(w_cnt_clk) + 1) == MAX_CYCLES);

  always_comb begin
    w_hex_next = '0;
    case (w_sel)
      HEX_PC:     w_hex_next = bus.pc;
      HEX_INSTR:  w_hex_next = bus.instr;
      HEX_ALU:    w_hex_next = bus.alu_result;
      HEX_CNT_IR: w_hex_next = 32'({w_cnt_i, w_cnt_r});
      HEX_CNT_JC: w_hex_next = 32'({w_cnt_j, w_cnt_clk});
      HEX_STATUS: w_hex_next = 32'({r_limit_hit, r_bp_skip, r_state});
      default:    w_hex_next = '0;
    endcase
  end

  always_ff @(posedge external_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_halted    <= 1'b0;
      r_step_q    <= 1'b0;
      r_bp_skip   <= 1'b0;
      r_limit_hit <= 1'b0;
      r_hex       <= '0;
    end else begin
      r_step_q <= bus.step;
      r_hex    <= w_hex_next;
      if (w_limit_now) r_limit_hit <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.run) begin
            r_state   <= RUN;
            r_bp_skip <= 1'b1;
          end else if (w_step_edge) begin
            r_state <= STEP;
          end
        end
        RUN: begin
          r_bp_skip <= 1'b0;
          if (w_limit_now || w_bp_hit) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (!bus.run) begin
            r_state <= IDLE;
          end
        end
        STEP: begin
          if (w_limit_now) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        HALT: begin
          if (!bus.run && !bus.step && !r_limit_hit) begin
            r_state  <= IDLE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  instr_class_counter #(.CNT_W(CNT_W)) u_cnt_clk (
    .i_clk (external_clk),
    .i_rst (reset),
    .i_en  (w_cpu_en),
    .o_cnt (w_cnt_clk)
  );

  instr_class_counter #(.CNT_W(CNT_W)) u_cnt_r (
    .i_clk (external_clk),
    .i_rst (reset),
    .i_en  (w_cpu_en && (w_opcode == OP_RTYPE)),
    .o_cnt (w_cnt_r)
  );

  instr_class_counter #(.CNT_W(CNT_W)) u_cnt_j (
    .i_clk (external_clk),
    .i_rst (reset),
    .i_en  (w_cpu_en && is_jump(w_opcode)),
    .o_cnt (w_cnt_j)
  );

  instr_class_counter #(.CNT_W(CNT_W)) u_cnt_i (
    .i_clk (external_clk),
    .i_rst (reset),
    .i_en  (w_cpu_en && (w_opcode != OP_RTYPE) && !is_jump(w_opcode)),
    .o_cnt (w_cnt_i)
  );

  assign bus.cpu_en  = w_cpu_en;
  assign bus.halted  = r_halted;
  assign bus.cnt_i   = w_cnt_i;
  assign bus.cnt_r   = w_cnt_r;
  assign bus.cnt_j   = w_cnt_j;
  assign bus.cnt_clk = w_cnt_clk;
  assign bus.hex     = r_hex;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: a full-size instance (CNT_W=11,
// MAX_CYCLES=1700) and a narrow instance (CNT_W=4) for saturation.
module tb_cpu_run_controller;

  localparam logic [31:0] INSTR_R  = 32'h0000_0020;  // opcode 0x00
  localparam logic [31:0] INSTR_LW = 32'h8C00_0000;  // opcode 0x23
  localparam logic [31:0] INSTR_J  = 32'h0800_0000;  // opcode 0x02

  logic clk;
  logic rst_m;
  logic rst_s;
  int   vec;
  int   errs;

  cpu_run_controller_if #(.CNT_W(11)) mi ();
  cpu_run_controller_if #(.CNT_W(4))  si ();

  cpu_run_controller #(.CNT_W(11), .MAX_CYCLES(1700)) u_dut (
    .external_clk (clk),
    .reset        (rst_m),
    .bus          (mi)
  );

  cpu_run_controller #(.CNT_W(4), .MAX_CYCLES(30)) u_sat (
    .external_clk (clk),
    .reset        (rst_s),
    .bus          (si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [2:0] s);
    mi.expsrc0 = s[0];
    mi.expsrc1 = s[1];
    mi.expsrc2 = s[2];
  endtask

  task automatic init_inputs();
    mi.run = 0; mi.step = 0; mi.bp_en = 0; mi.bp_addr = '0;
    mi.pc = '0; mi.instr = '0; mi.alu_result = '0;
    set_sel(3'd0);
    si.run = 0; si.step = 0; si.bp_en = 0; si.bp_addr = '0;
    si.pc = '0; si.instr = '0; si.alu_result = '0;
    si.expsrc0 = 0; si.expsrc1 = 0; si.expsrc2 = 0;
  endtask

  task automatic do_reset_m();
    rst_m = 1'b1;
    tick();
    tick();
    rst_m = 1'b0;
  endtask

  task automatic test_reset();
    init_inputs();
    mi.run = 1'b1;
    rst_m = 1'b1;
    rst_s = 1'b1;
    tick();
    tick();
    rst_m = 1'b0;
    rst_s = 1'b0;
    #1;
    vec++; if (mi.cpu_en !== 1'b0) begin errs++; $display("FAIL reset_cpu_en: got %0b want 0", mi.cpu_en); end
    vec++; if (mi.halted !== 1'b0) begin errs++; $display("FAIL reset_halted: got %0b want 0", mi.halted); end
    vec++; if (mi.cnt_clk !== 11'd0 || mi.cnt_i !== 11'd0 || mi.cnt_r !== 11'd0 || mi.cnt_j !== 11'd0) begin
      errs++; $display("FAIL reset_counters: got clk=%0d i=%0d r=%0d j=%0d want all 0", mi.cnt_clk, mi.cnt_i, mi.cnt_r, mi.cnt_j);
    end
    vec++; if (mi.hex !== 32'h0) begin errs++; $display("FAIL reset_hex: got %h want 0", mi.hex); end
    vec++; if (si.cnt_clk !== 4'd0) begin errs++; $display("FAIL reset_sat_clk: got %0d want 0", si.cnt_clk); end
    mi.run = 1'b0;
    set_sel(3'd5);
    tick();
    vec++; if (mi.hex !== 32'h0) begin errs++; $display("FAIL reset_status: got %h want 0", mi.hex); end
    set_sel(3'd0);
  endtask

  task automatic test_run();
    do_reset_m();
    mi.bp_en = 1'b0;
    mi.run = 1'b1;
    tick();
    vec++; if (mi.cpu_en !== 1'b1) begin errs++; $display("FAIL run_cpu_en: got %0b want 1", mi.cpu_en); end
    for (int k = 0; k < 10; k++) begin
      mi.instr = (k % 2 == 0) ? INSTR_R : INSTR_LW;
      mi.pc = 32'(k * 4);
      if (k == 9) mi.run = 1'b0;
      tick();
    end
    vec++; if (mi.cnt_clk !== 11'd10) begin errs++; $display("FAIL run_cnt_clk: got %0d want 10", mi.cnt_clk); end
    vec++; if (mi.cnt_r !== 11'd5) begin errs++; $display("FAIL run_cnt_r: got %0d want 5", mi.cnt_r); end
    vec++; if (mi.cnt_i !== 11'd5) begin errs++; $display("FAIL run_cnt_i: got %0d want 5", mi.cnt_i); end
    vec++; if (mi.cnt_j !== 11'd0) begin errs++; $display("FAIL run_cnt_j: got %0d want 0", mi.cnt_j); end
    vec++; if (mi.cpu_en !== 1'b0) begin errs++; $display("FAIL run_stop_en: got %0b want 0", mi.cpu_en); end
  endtask

  // Runs straight after test_run: counters hold i=5 r=5 j=0 clk=10, state IDLE.
  task automatic test_hex();
    logic [31:0] exp_hex [8];
    mi.pc = 32'h0040_0000;
    mi.instr = 32'h0800_0001;
    mi.alu_result = 32'hDEAD_BEEF;
    exp_hex[0] = 32'h0040_0000;
    exp_hex[1] = 32'h0800_0001;
    exp_hex[2] = 32'hDEAD_BEEF;
    exp_hex[3] = 32'h0000_2805;
    exp_hex[4] = 32'h0000_000A;
    exp_hex[5] = 32'h0000_0000;
    exp_hex[6] = 32'h0000_0000;
    exp_hex[7] = 32'h0000_0000;
    for (int k = 0; k < 8; k++) begin
      set_sel(3'(k));
      #1;
      if (k > 0) begin
        vec++; if (mi.hex !== exp_hex[k-1]) begin errs++; $display("FAIL hex_lag_%0d: got %h want %h", k, mi.hex, exp_hex[k-1]); end
      end
      tick();
      vec++; if (mi.hex !== exp_hex[k]) begin errs++; $display("FAIL hex_sel_%0d: got %h want %h", k, mi.hex, exp_hex[k]); end
    end
    set_sel(3'd0);
    tick();
    mi.pc = 32'h0040_0004;
    #1;
    vec++; if (mi.hex !== 32'h0040_0000) begin errs++; $display("FAIL hex_data_lag: got %h want 00400000", mi.hex); end
    tick();
    vec++; if (mi.hex !== 32'h0040_0004) begin errs++; $display("FAIL hex_data_new: got %h want 00400004", mi.hex); end
  endtask

  task automatic test_breakpoint();
    do_reset_m();
    mi.instr = INSTR_LW;
    mi.bp_en = 1'b1;
    mi.bp_addr = 32'h0000_0010;
    set_sel(3'd5);
    mi.pc = 32'h0;
    mi.run = 1'b1;
    tick();
    vec++; if (mi.cpu_en !== 1'b1) begin errs++; $display("FAIL bp_first_en: got %0b want 1", mi.cpu_en); end
    tick();
    vec++; if (mi.hex !== 32'h5) begin errs++; $display("FAIL bp_status_skip: got %h want 5", mi.hex); end
    mi.pc = 32'h4; tick();
    mi.pc = 32'h8; tick();
    mi.pc = 32'hC; tick();
    mi.pc = 32'h10;
    #1;
    vec++; if (mi.cpu_en !== 1'b0) begin errs++; $display("FAIL bp_hit_en: got %0b want 0", mi.cpu_en); end
    vec++; if (mi.halted !== 1'b0) begin errs++; $display("FAIL bp_pre_halted: got %0b want 0", mi.halted); end
    tick();
    vec++; if (mi.halted !== 1'b1) begin errs++; $display("FAIL bp_halted: got %0b want 1", mi.halted); end
    vec++; if (mi.cnt_clk !== 11'd4) begin errs++; $display("FAIL bp_cnt_clk: got %0d want 4", mi.cnt_clk); end
    tick();
    vec++; if (mi.hex !== 32'h3 || mi.cpu_en !== 1'b0) begin
      errs++; $display("FAIL bp_halt_status: got hex=%h en=%0b want hex=3 en=0", mi.hex, mi.cpu_en);
    end
    mi.run = 1'b0;
    tick();
    vec++; if (mi.halted !== 1'b0) begin errs++; $display("FAIL bp_release: got %0b want 0", mi.halted); end
    mi.run = 1'b1;
    tick();
    vec++; if (mi.cpu_en !== 1'b1) begin errs++; $display("FAIL bp_resume_en: got %0b want 1", mi.cpu_en); end
    tick();
    mi.pc = 32'h14;
    #1;
    vec++; if (mi.cpu_en !== 1'b1) begin errs++; $display("FAIL bp_past_en: got %0b want 1", mi.cpu_en); end
    tick();
    vec++; if (mi.cnt_clk !== 11'd6 || mi.halted !== 1'b0) begin
      errs++; $display("FAIL bp_continue: got clk=%0d halted=%0b want clk=6 halted=0", mi.cnt_clk, mi.halted);
    end
    mi.run = 1'b0;
    mi.bp_en = 1'b0;
    set_sel(3'd0);
    tick();
  endtask

  task automatic test_step();
    int en_seen;
    do_reset_m();
    mi.instr = INSTR_J;
    mi.bp_en = 1'b1;
    mi.bp_addr = 32'h40;
    mi.pc = 32'h40;
    en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      mi.step = 1'b1;
      repeat (4) begin tick(); if (mi.cpu_en === 1'b1) en_seen++; end
      mi.step = 1'b0;
      repeat (4) begin tick(); if (mi.cpu_en === 1'b1) en_seen++; end
    end
    vec++; if (en_seen != 3) begin errs++; $display("FAIL step_enables: got %0d want 3", en_seen); end
    vec++; if (mi.cnt_j !== 11'd3) begin errs++; $display("FAIL step_cnt_j: got %0d want 3", mi.cnt_j); end
    vec++; if (mi.cnt_clk !== 11'd3 || mi.cnt_i !== 11'd0) begin
      errs++; $display("FAIL step_cnt_other: got clk=%0d i=%0d want clk=3 i=0", mi.cnt_clk, mi.cnt_i);
    end
    en_seen = 0;
    mi.step = 1'b1;
    repeat (20) begin tick(); if (mi.cpu_en === 1'b1) en_seen++; end
    mi.step = 1'b0;
    tick(); if (mi.cpu_en === 1'b1) en_seen++;
    vec++; if (en_seen != 1) begin errs++; $display("FAIL step_hold: got %0d want 1", en_seen); end
    vec++; if (mi.cnt_j !== 11'd4) begin errs++; $display("FAIL step_hold_cnt_j: got %0d want 4", mi.cnt_j); end
    mi.bp_en = 1'b0;
  endtask

  task automatic test_limit();
    do_reset_m();
    mi.instr = INSTR_LW;
    mi.run = 1'b1;
    for (int c = 0; c < 2000 && mi.halted !== 1'b1; c++) tick();
    vec++; if (mi.halted !== 1'b1) begin errs++; $display("FAIL limit_timeout: got halted=%0b want 1", mi.halted); end
    vec++; if (mi.cnt_clk !== 11'd1700) begin errs++; $display("FAIL limit_cnt_clk: got %0d want 1700", mi.cnt_clk); end
    vec++; if (mi.cnt_i !== 11'd1700) begin errs++; $display("FAIL limit_cnt_i: got %0d want 1700", mi.cnt_i); end
    mi.run = 1'b0;
    repeat (3) tick();
    vec++; if (mi.halted !== 1'b1) begin errs++; $display("FAIL limit_sticky_run0: got %0b want 1", mi.halted); end
    mi.step = 1'b1;
    repeat (2) tick();
    mi.step = 1'b0;
    mi.run = 1'b1;
    repeat (3) tick();
    vec++; if (mi.cpu_en !== 1'b0 || mi.cnt_clk !== 11'd1700) begin
      errs++; $display("FAIL limit_frozen: got en=%0b clk=%0d want en=0 clk=1700", mi.cpu_en, mi.cnt_clk);
    end
    set_sel(3'd5);
    repeat (2) tick();
    vec++; if (mi.hex !== 32'hB) begin errs++; $display("FAIL limit_status: got %h want b", mi.hex); end
    set_sel(3'd0);
    mi.run = 1'b0;
    do_reset_m();
    #1;
    vec++; if (mi.halted !== 1'b0 || mi.cnt_clk !== 11'd0) begin
      errs++; $display("FAIL limit_reset: got halted=%0b clk=%0d want 0 0", mi.halted, mi.cnt_clk);
    end
  endtask

  task automatic test_saturation();
    rst_s = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;
    si.instr = INSTR_R;
    si.run = 1'b1;
    tick();
    repeat (20) tick();
    vec++; if (si.cnt_r !== 4'd15) begin errs++; $display("FAIL sat_cnt_r: got %0d want 15", si.cnt_r); end
    vec++; if (si.cnt_clk !== 4'd15) begin errs++; $display("FAIL sat_cnt_clk: got %0d want 15", si.cnt_clk); end
    vec++; if (si.cnt_i !== 4'd0 || si.halted !== 1'b0 || si.cpu_en !== 1'b1) begin
      errs++; $display("FAIL sat_state: got i=%0d halted=%0b en=%0b want 0 0 1", si.cnt_i, si.halted, si.cpu_en);
    end
    si.run = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset_m();
    mi.instr = INSTR_R;
    mi.run = 1'b1;
    repeat (4) tick();
    rst_m = 1'b1;
    tick();
    rst_m = 1'b0;
    #1;
    vec++; if (mi.cpu_en !== 1'b0 || mi.cnt_clk !== 11'd0 || mi.cnt_r !== 11'd0) begin
      errs++; $display("FAIL midrun_reset: got en=%0b clk=%0d r=%0d want 0 0 0", mi.cpu_en, mi.cnt_clk, mi.cnt_r);
    end
    tick();
    vec++; if (mi.cpu_en !== 1'b1) begin errs++; $display("FAIL midrun_rerun: got %0b want 1", mi.cpu_en); end
    mi.run = 1'b0;
    tick();
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst_m = 1'b1;
    rst_s = 1'b1;
    test_reset();
    test_run();
    test_hex();
    test_breakpoint();
    test_step();
    test_limit();
    test_saturation();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
